pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage core. It watches hazards and memory handshakes and drives the stall and clear inputs of every pipeline register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also drives the PC source select. It is the only block allowed to assert `stall`/`clr` on `ifid_register` and its sibling stage registers.

## Interface
- `REG_AW`, default 5: register-index width.
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in REG_AW each: source indices of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` in 1 each: source actually read.
- `ex_rd` in REG_AW: destination index of the instruction in EX.
- `ex_mem_read` in 1: instruction in EX is a load.
- `ex_redirect` in 1: taken branch or jump resolved in EX (target on datapath).
- `mem_exc` in 1: exception raised by the instruction in MEM.
- `imem_ready` in 1: fetch response valid this cycle.
- `dmem_busy` in 1: data memory has not yet completed the MEM-stage access.
- `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall`, `memwb_stall` out 1 each: hold the register.
- `ifid_clr`, `idex_clr`, `exmem_clr`, `memwb_clr` out 1 each: load a bubble. IF/ID loads NOP 32'h00000033.
- `pc_sel` out 2: 0 = PC+4, 1 = EX target, 2 = trap vector.
- `stall_cnt` out CNT_W: cycles with `pc_stall` high, saturating.

## Operation
- FSM states:
  - RUN: normal operation.
  - DRAIN: a redirect occurred while a fetch was outstanding. Discard exactly one stale `imem_ready` response.
  - DWAIT: `dmem_busy` is pending.
- Priority per cycle, highest first: DWAIT/dmem_busy > mem_exc > ex_redirect > imem miss/DRAIN > load-use.
- dmem_busy (any state):
  - Assert all five stalls and `memwb_clr`; outputs of lower-priority rules are suppressed.
  - Enter DWAIT, remembering the prior state.
  - Return to the prior state in the first cycle `dmem_busy` is low.
- mem_exc:
  - `pc_sel`=2; clear IF/ID, ID/EX, EX/MEM; no stalls.
  - Next state: DRAIN if `imem_ready`=0 this cycle, else RUN.
- ex_redirect:
  - `pc_sel`=1; clear IF/ID and ID/EX.
  - Next state: DRAIN if `imem_ready`=0 this cycle, else RUN.
- Imem miss (RUN, `imem_ready`=0):
  - Assert `pc_stall` and `ifid_clr`; downstream stages advance.
- DRAIN:
  - Assert `ifid_clr`; PC advances normally from the redirect target.
  - Go to RUN on the first cycle `imem_ready`=1. That response is dropped.
- Load-use (RUN, `imem_ready`=1):
  - Condition: `ex_mem_read` && `ex_rd`!=0 && ((`id_rs1_used` && `id_rs1`==`ex_rd`) || (`id_rs2_used` && `id_rs2`==`ex_rd`)).
  - Response: `pc_stall`, `ifid_stall`, `idex_clr` for one cycle.
- A stall and a clear are never asserted together on the same register. Clear wins, and the stall is dropped.

## Timing
- All stall, clear and `pc_sel` outputs are combinational from inputs and the registered state. They act at the next rising edge.
- Reset values:
  - State = RUN.
  - `stall_cnt` = 0.
  - While `rst` is low, all four clears are 1 and all stalls are 0.
  - `pc_sel` = 0.
- Reset mid-DWAIT or mid-DRAIN drops to RUN with no pending discard.
- Load-use bubble costs exactly 1 cycle. A redirect costs 2 bubbles, plus 1 per DRAIN cycle.
- `stall_cnt` increments on every edge where `pc_stall` was high and saturates at all-ones.

## Structure
- Shared `titan_pkg`:
  - FSM state encoding (RUN/DRAIN/DWAIT).
  - `pc_sel` encodings (PCSEL_PLUS4, PCSEL_TARGET, PCSEL_TRAP).
  - NOP constant 32'h00000033.
- Sub-module `hazard_detect`: combinational load-use comparator, instantiated once.
- FSM, priority mux and counter stay in `pipeline_ctrl`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles -> all clears 1, stalls 0, `stall_cnt`=0. After release, RUN with no outputs asserted given idle inputs.
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_rs2_used`=1 -> exactly one cycle of `pc_stall`/`ifid_stall`/`idex_clr`; `stall_cnt`=1. Repeat with `ex_rd`=0 -> no stall.
- Redirect during miss: `imem_ready`=0 and `ex_redirect`=1 -> `pc_sel`=1, IF/ID and ID/EX clear. Next response is discarded (`ifid_clr` on the `imem_ready`=1 cycle), then RUN.
- Exception vs branch same cycle: `mem_exc`=1 and `ex_redirect`=1 -> `pc_sel`=2, EX/MEM cleared.
- Dmem wait: `dmem_busy`=1 for 4 cycles while `mem_exc`=1 -> all stalls plus `memwb_clr` for 4 cycles, no trap. Trap taken on the cycle `dmem_busy` falls.
- Counter saturation: `CNT_W`=4, 20 stall cycles -> `stall_cnt`=15.

Source files
------------

// File: rtl/titan_pkg.sv
// rtl/titan_pkg.sv - shared encodings for the pipeline control slice
package titan_pkg;

   // Sequencer states: normal flow, one stale fetch to discard, data-memory wait
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DWAIT = 2'd2
   } state_e;

   localparam logic [1:0] PCSEL_PLUS4  = 2'd0;
   localparam logic [1:0] PCSEL_TARGET = 2'd1;
   localparam logic [1:0] PCSEL_TRAP   = 2'd2;

   // Bubble instruction the IF/ID register loads on a clear
   localparam logic [31:0] NOP_INSN = 32'h00000033;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - load-use hazard comparator
module hazard_detect #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   output logic              load_use
);

   // A load in EX whose result the ID instruction reads; x0 never creates a dependency
   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) ||
                  (id_rs2_used && (id_rs2 == ex_rd)));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the five-stage core
module pipeline_ctrl
   import titan_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_redirect,
   input  logic              mem_exc,
   input  logic              imem_ready,
   input  logic              dmem_busy,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_stall,
   output logic              exmem_stall,
   output logic              memwb_stall,
   output logic              ifid_clr,
   output logic              idex_clr,
   output logic              exmem_clr,
   output logic              memwb_clr,
   output logic [1:0]        pc_sel,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_e             state_q, state_d;
   state_e             saved_q, saved_d;
   state_e             eff_state;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               load_use;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   // State, pre-wait state and stall counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         saved_q     <= ST_RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         saved_q     <= saved_q == saved_d ? saved_q : saved_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // The cycle dmem_busy drops is already handled under the pre-wait state's rules
   always_comb begin
      eff_state = state_q;
      if (state_q == ST_DWAIT && !dmem_busy) eff_state = saved_q;
   end

   // Next-state selection in rule priority order
   always_comb begin
      state_d = ST_RUN;
      saved_d = saved_q;
      if (dmem_busy) begin
         state_d = ST_DWAIT;
         if (state_q != ST_DWAIT) saved_d = state_q;
      end else if (mem_exc || ex_redirect || eff_state == ST_DRAIN) begin
         state_d = imem_ready ? ST_RUN : ST_DRAIN;
      end
   end

   // Stall/clear/pc_sel priority mux; no branch ever stalls and clears one register
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      memwb_stall = 1'b0;
      ifid_clr    = 1'b0;
      idex_clr    = 1'b0;
      exmem_clr   = 1'b0;
      memwb_clr   = 1'b0;
      pc_sel      = PCSEL_PLUS4;
      if (!rst) begin
         ifid_clr  = 1'b1;
         idex_clr  = 1'b1;
         exmem_clr = 1'b1;
         memwb_clr = 1'b1;
      end else if (dmem_busy) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_clr   = 1'b1;
      end else if (mem_exc) begin
         pc_sel    = PCSEL_TRAP;
         ifid_clr  = 1'b1;
         idex_clr  = 1'b1;
         exmem_clr = 1'b1;
      end else if (ex_redirect) begin
         pc_sel   = PCSEL_TARGET;
         ifid_clr = 1'b1;
         idex_clr = 1'b1;
      end else if (eff_state == ST_DRAIN) begin
         ifid_clr = 1'b1;
      end else if (!imem_ready) begin
         pc_stall = 1'b1;
         ifid_clr = 1'b1;
      end else if (load_use) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_clr   = 1'b1;
      end
   end

   // Saturating count of cycles the PC was held
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic [4:0]  rd;
      logic        mr;
      logic        redir;
      logic        exc;
      logic        ird;
      logic        busy;
      logic [10:0] exp;
   } vec_t;

   // Output vector order: pc,ifid,idex,exmem,memwb stalls | ifid,idex,exmem,memwb clears | pc_sel
   localparam logic [10:0] O_IDLE  = 11'b00000_0000_00;
   localparam logic [10:0] O_MISS  = 11'b10000_1000_00;
   localparam logic [10:0] O_LU    = 11'b11000_0100_00;
   localparam logic [10:0] O_REDIR = 11'b00000_1100_01;
   localparam logic [10:0] O_TRAP  = 11'b00000_1110_10;
   localparam logic [10:0] O_BUSY  = 11'b11110_0001_00;
   localparam logic [10:0] O_DRAIN = 11'b00000_1000_00;
   localparam logic [10:0] O_RST   = 11'b00000_1111_00;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_exc, imem_ready, dmem_busy;

   logic a_pcs, a_ifs, a_ids, a_exs, a_mws, a_ifc, a_idc, a_exc, a_mwc;
   logic [1:0] a_sel;
   logic [31:0] a_cnt;
   logic b_pcs, b_ifs, b_ids, b_exs, b_mws, b_ifc, b_idc, b_exc, b_mwc;
   logic [1:0] b_sel;
   logic [3:0] b_cnt;
   logic [10:0] act_a, act_b;

   int checks = 0;
   int errors = 0;
   int m_mode, m_saved;   // 0 normal, 1 discarding a stale fetch, 2 waiting on dmem
   longint m_cnt;

   always #5 clk = ~clk;

   pipeline_ctrl dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_exc(mem_exc),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .pc_stall(a_pcs), .ifid_stall(a_ifs), .idex_stall(a_ids), .exmem_stall(a_exs),
      .memwb_stall(a_mws), .ifid_clr(a_ifc), .idex_clr(a_idc), .exmem_clr(a_exc),
      .memwb_clr(a_mwc), .pc_sel(a_sel), .stall_cnt(a_cnt));

   pipeline_ctrl #(.REG_AW(5), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_exc(mem_exc),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .pc_stall(b_pcs), .ifid_stall(b_ifs), .idex_stall(b_ids), .exmem_stall(b_exs),
      .memwb_stall(b_mws), .ifid_clr(b_ifc), .idex_clr(b_idc), .exmem_clr(b_exc),
      .memwb_clr(b_mwc), .pc_sel(b_sel), .stall_cnt(b_cnt));

   assign act_a = {a_pcs, a_ifs, a_ids, a_exs, a_mws, a_ifc, a_idc, a_exc, a_mwc, a_sel};
   assign act_b = {b_pcs, b_ifs, b_ids, b_exs, b_mws, b_ifc, b_idc, b_exc, b_mwc, b_sel};

   function automatic vec_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit mr, input bit redir, input bit exc,
                               input bit ird, input bit busy, input logic [10:0] exp);
      vec_t v;
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 5'(rd);
      v.mr = mr; v.redir = redir; v.exc = exc; v.ird = ird; v.busy = busy; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input string name);
      chk({name, " cnt32"}, a_cnt, 32'(m_cnt));
      chk({name, " cnt4"}, 32'(b_cnt), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
   endtask

   // Hold reset for n cycles; clears must be up, stalls down, counters zero
   task automatic do_reset(input int n);
      rst = 1'b0;
      m_mode = 0; m_saved = 0; m_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("reset outputs", 32'(act_a), 32'(O_RST));
         chk_cnt("reset");
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
   endtask

   // Apply one cycle of inputs, compare with the reference rules, then advance the model
   task automatic step(input vec_t v, input bit use_exp, input string name);
      int eff;
      bit lu;
      logic [10:0] e;
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
      ex_rd = v.rd; ex_mem_read = v.mr; ex_redirect = v.redir; mem_exc = v.exc;
      imem_ready = v.ird; dmem_busy = v.busy;
      eff = (m_mode == 2 && !v.busy) ? m_saved : m_mode;
      lu = v.mr && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      if (v.busy)         e = O_BUSY;
      else if (v.exc)     e = O_TRAP;
      else if (v.redir)   e = O_REDIR;
      else if (eff == 1)  e = O_DRAIN;
      else if (!v.ird)    e = O_MISS;
      else if (lu)        e = O_LU;
      else                e = O_IDLE;
      @(negedge clk);
      chk({name, " model"}, 32'(act_a), 32'(e));
      chk({name, " model w4"}, 32'(act_b), 32'(e));
      if (use_exp) chk({name, " table"}, 32'(act_a), 32'(v.exp));
      chk_cnt(name);
      @(posedge clk);
      if (v.busy) begin
         if (m_mode != 2) m_saved = m_mode;
         m_mode = 2;
      end else if (v.exc || v.redir || eff == 1) begin
         m_mode = v.ird ? 0 : 1;
      end else begin
         m_mode = 0;
      end
      if (e[10]) m_cnt++;
      #1;
   endtask

   vec_t tbl[12];
   vec_t idle, v;

   initial begin
      rst = 1'b0;
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_rs1_used = 0; id_rs2_used = 0;
      ex_mem_read = 0; ex_redirect = 0; mem_exc = 0; imem_ready = 1; dmem_busy = 0;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IDLE);

      tbl[0]  = mk(1, 2, 1, 1, 3, 0, 0, 0, 1, 0, O_IDLE);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MISS);
      tbl[2]  = mk(7, 1, 1, 0, 7, 1, 0, 0, 1, 0, O_LU);
      tbl[3]  = mk(7, 1, 0, 1, 7, 1, 0, 0, 1, 0, O_IDLE);
      tbl[4]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 0, O_IDLE);
      tbl[5]  = mk(9, 9, 1, 1, 9, 0, 0, 0, 1, 0, O_IDLE);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, O_REDIR);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, O_TRAP);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_BUSY);
      tbl[9]  = mk(4, 4, 1, 1, 4, 1, 1, 0, 1, 0, O_REDIR);
      tbl[10] = mk(4, 4, 1, 1, 4, 1, 0, 0, 0, 0, O_MISS);
      tbl[11] = mk(3, 31, 0, 1, 31, 1, 0, 0, 1, 0, O_LU);

      // Reset for 3 cycles, then idle RUN
      do_reset(3);
      step(idle, 1, "post-reset idle");

      for (int i = 0; i < 12; i++) begin
         do_reset(1);
         step(tbl[i], 1, $sformatf("vec%0d", i));
      end

      // Load-use: one bubble, one counted stall; x0 destination never stalls
      do_reset(1);
      step(mk(0, 5, 0, 1, 5, 1, 0, 0, 1, 0, O_LU), 1, "lu hit");
      step(idle, 1, "lu after");
      chk("lu count", a_cnt, 32'd1);
      step(mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, O_IDLE), 1, "lu rd0");

      // Redirect while fetch outstanding: stale response dropped, then RUN
      do_reset(1);
      step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_REDIR), 1, "redir miss");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN), 1, "drain wait");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_DRAIN), 1, "drain drop");
      step(idle, 1, "drain done");

      // Exception beats a branch in the same cycle
      do_reset(1);
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, O_TRAP), 1, "exc vs br");

      // dmem wait holds the trap until busy falls
      do_reset(1);
      for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_BUSY), 1, "dwait");
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_TRAP), 1, "dwait trap");
      step(idle, 1, "dwait after");

      // Busy arriving during DRAIN returns to DRAIN
      do_reset(1);
      step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_REDIR), 1, "redir2");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_BUSY), 1, "busy in drain");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_DRAIN), 1, "back to drain");
      step(idle, 1, "drain2 done");

      // Reset mid-DWAIT and mid-DRAIN lands in RUN with nothing pending
      do_reset(1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_BUSY), 1, "pre-rst busy");
      do_reset(1);
      step(idle, 1, "rst from dwait");
      step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_REDIR), 1, "pre-rst redir");
      do_reset(1);
      step(idle, 1, "rst from drain");

      // Saturation of the narrow counter
      do_reset(1);
      for (int i = 0; i < 20; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MISS), 1, "sat miss");
      step(idle, 1, "sat idle");
      chk("sat cnt4", 32'(b_cnt), 32'd15);
      chk("sat cnt32", a_cnt, 32'd20);

      // Randomised traffic against the reference rules
      do_reset(1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset(1);
         v.rs1 = 5'($urandom_range(0, 3));
         v.rs2 = 5'($urandom_range(0, 3));
         v.rd  = 5'($urandom_range(0, 3));
         v.u1 = 1'($urandom); v.u2 = 1'($urandom); v.mr = 1'($urandom);
         v.redir = ($urandom_range(0, 5) == 0);
         v.exc   = ($urandom_range(0, 9) == 0);
         v.ird   = ($urandom_range(0, 3) != 0);
         v.busy  = ($urandom_range(0, 5) == 0);
         v.exp   = O_IDLE;
         step(v, 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
